// File: rtl/video_mem_arbiter.sv
// Time-slot arbiter sharing one 8-bit async SRAM between the video fetch path and the CPU.
// phase | meaning
// 0-3   | video RAM slot: strobe high, address in 1, oe_n low 1-2, capture entering 3
// 4-7   | char ROM slot: same timing as 0-3, shifted by 4
// 8-15  | CPU slot: request sampled entering 8, oe_n/we_n low 9-11, ack in 12
module video_mem_arbiter #(
    parameter logic [16:0] VRAM_BASE = 17'h08000,
    parameter logic [16:0] CROM_BASE = 17'h10000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        char_sync,
    input  logic [11:0] video_addr,
    output logic [7:0]  video_data,
    output logic        video_ram_strobe,
    output logic        video_rom_strobe,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [16:0] sram_addr,
    input  logic [7:0]  sram_din,
    output logic [7:0]  sram_dout,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    logic [3:0]  phase, phase_nxt;
    logic        grant, grant_nxt;
    logic        grant_we, grant_we_nxt;

    logic [7:0]  video_data_nxt, cpu_rdata_nxt, sram_dout_nxt;
    logic [16:0] sram_addr_nxt;
    logic        ram_strobe_nxt, rom_strobe_nxt, cpu_ack_nxt;
    logic        oe_n_nxt, we_n_nxt, cpu_active;
    logic [11:0] video_off;

    // Bit 11 of the fetch address has no meaning here; masking it keeps the offset 11 bits.
    assign video_off = video_addr & 12'h7FF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase            <= 4'd0;
            grant            <= 1'b0;
            grant_we         <= 1'b0;
            video_ram_strobe <= 1'b0;
            video_rom_strobe <= 1'b0;
            video_data       <= 8'h00;
            cpu_rdata        <= 8'h00;
            cpu_ack          <= 1'b0;
            sram_addr        <= 17'h00000;
            sram_dout        <= 8'h00;
            sram_oe_n        <= 1'b1;
            sram_we_n        <= 1'b1;
        end else begin
            phase            <= phase_nxt;
            grant            <= grant_nxt;
            grant_we         <= grant_we_nxt;
            video_ram_strobe <= ram_strobe_nxt;
            video_rom_strobe <= rom_strobe_nxt;
            video_data       <= video_data_nxt;
            cpu_rdata        <= cpu_rdata_nxt;
            cpu_ack          <= cpu_ack_nxt;
            sram_addr        <= sram_addr_nxt;
            sram_dout        <= sram_dout_nxt;
            sram_oe_n        <= oe_n_nxt;
            sram_we_n        <= we_n_nxt;
        end
    end

    always_comb begin
        phase_nxt    = char_sync ? 4'd0 : phase + 4'd1;
        grant_nxt    = grant;
        grant_we_nxt = grant_we;
        if (phase_nxt == 4'd8) begin
            grant_nxt    = cpu_req;
            grant_we_nxt = cpu_we;
        end
    end

    // Outputs are registered, so everything is decoded from the phase about to be entered.
    // An abort by char_sync needs no extra logic: phase 0 decodes to an idle SRAM bus.
    always_comb begin
        ram_strobe_nxt = (phase_nxt <= 4'd3);
        rom_strobe_nxt = (phase_nxt >= 4'd4) && (phase_nxt <= 4'd7);
        cpu_active     = grant_nxt && (phase_nxt >= 4'd9) && (phase_nxt <= 4'd11);

        oe_n_nxt = !((phase_nxt == 4'd1) || (phase_nxt == 4'd2) ||
                     (phase_nxt == 4'd5) || (phase_nxt == 4'd6) ||
                     (cpu_active && !grant_we_nxt));
        we_n_nxt = !(cpu_active && grant_we_nxt);

        sram_addr_nxt = sram_addr;
        if (phase_nxt == 4'd1)
            sram_addr_nxt = VRAM_BASE + {5'b0, video_off};
        else if (phase_nxt == 4'd5)
            sram_addr_nxt = CROM_BASE + {5'b0, video_off};
        else if ((phase_nxt == 4'd8) && cpu_req)
            sram_addr_nxt = cpu_addr;

        sram_dout_nxt = sram_dout;
        if ((phase_nxt == 4'd8) && cpu_req && cpu_we)
            sram_dout_nxt = cpu_wdata;

        video_data_nxt = video_data;
        if ((phase_nxt == 4'd3) || (phase_nxt == 4'd7))
            video_data_nxt = sram_din;

        cpu_ack_nxt   = (phase_nxt == 4'd12) && grant_nxt;
        cpu_rdata_nxt = cpu_rdata;
        if (cpu_ack_nxt && !grant_we_nxt)
            cpu_rdata_nxt = sram_din;
    end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter with a behavioural async SRAM model.
module tb_video_mem_arbiter;

    logic        clk, reset_n, char_sync;
    logic [11:0] video_addr;
    logic [7:0]  video_data;
    logic        video_ram_strobe, video_rom_strobe;
    logic        cpu_req, cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic [16:0] sram_addr;
    logic [7:0]  sram_din, sram_dout;
    logic        sram_oe_n, sram_we_n;

    logic [7:0]  w_video_data, w_cpu_rdata, w_sram_dout;
    logic        w_ram_strobe, w_rom_strobe, w_cpu_ack, w_oe_n, w_we_n;
    logic [16:0] w_sram_addr;

    logic [7:0]  mem [0:131071];
    logic [3:0]  ph;
    int          checks, errors, lat;

    video_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n), .char_sync(char_sync),
        .video_addr(video_addr), .video_data(video_data),
        .video_ram_strobe(video_ram_strobe), .video_rom_strobe(video_rom_strobe),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    video_mem_arbiter #(.VRAM_BASE(17'h1FFFF)) dut_w (
        .clk(clk), .reset_n(reset_n), .char_sync(char_sync),
        .video_addr(video_addr), .video_data(w_video_data),
        .video_ram_strobe(w_ram_strobe), .video_rom_strobe(w_rom_strobe),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(w_cpu_rdata), .cpu_ack(w_cpu_ack),
        .sram_addr(w_sram_addr), .sram_din(8'h00), .sram_dout(w_sram_dout),
        .sram_oe_n(w_oe_n), .sram_we_n(w_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_din = mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] = sram_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus-contention and write-window rules, sampled every cycle out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert (sram_oe_n || sram_we_n) else begin
                errors++;
                $error("FAIL oe_we_both_low: observed oe_n=%0b we_n=%0b expected not both 0", sram_oe_n, sram_we_n);
            end
            checks++;
            assert (sram_we_n || (ph >= 4'd9 && ph <= 4'd11)) else begin
                errors++;
                $error("FAIL we_window: observed we_n=0 in phase %0d expected only 9-11", ph);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (!reset_n || char_sync) ph = 4'd0;
        else ph = ph + 4'd1;
        @(negedge clk);
    endtask

    task automatic goto(input logic [3:0] p);
        for (int i = 0; i < 17 && ph != p; i++) cyc();
    endtask

    initial begin
        checks = 0; errors = 0; ph = 4'd0; lat = 0;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h08005] = 8'h41;
        mem[17'h1000A] = 8'h3C;
        reset_n = 1'b0; char_sync = 1'b0; video_addr = 12'h005;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 17'h0; cpu_wdata = 8'h00;
        repeat (3) cyc();

        chk("rst_ram_strobe", video_ram_strobe, 1'b0);
        chk("rst_rom_strobe", video_rom_strobe, 1'b0);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_ack", cpu_ack, 1'b0);
        chk("rst_addr", sram_addr, 17'h0);
        chk("rst_vdata", video_data, 8'h00);
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_dout", sram_dout, 8'h00);

        // align to phase 0 and walk the video RAM slot
        reset_n = 1'b1; char_sync = 1'b1;
        cyc(); char_sync = 1'b0;
        chk("p0_ram_strobe", video_ram_strobe, 1'b1);
        chk("p0_oe_n", sram_oe_n, 1'b1);
        cyc();
        chk("p1_addr", sram_addr, 17'h08005);
        chk("p1_oe_n", sram_oe_n, 1'b0);
        cyc();
        chk("p2_oe_n", sram_oe_n, 1'b0);
        cyc();
        chk("p3_vdata", video_data, 8'h41);
        chk("p3_oe_n", sram_oe_n, 1'b1);
        chk("p3_ram_strobe", video_ram_strobe, 1'b1);
        cyc();
        chk("p4_ram_strobe", video_ram_strobe, 1'b0);
        chk("p4_rom_strobe", video_rom_strobe, 1'b1);
        chk("p4_vdata", video_data, 8'h41);
        video_addr = 12'h80A;
        cyc();
        chk("p5_addr", sram_addr, 17'h1000A);
        chk("p5_oe_n", sram_oe_n, 1'b0);
        cyc();
        chk("p6_vdata_hold", video_data, 8'h41);
        cyc();
        chk("p7_vdata", video_data, 8'h3C);
        chk("p7_rom_strobe", video_rom_strobe, 1'b1);

        // CPU write of A5 to 00100
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00100; cpu_wdata = 8'hA5;
        cyc();
        chk("wr_p8_addr", sram_addr, 17'h00100);
        chk("wr_p8_dout", sram_dout, 8'hA5);
        chk("wr_p8_we_n", sram_we_n, 1'b1);
        chk("wr_p8_rom_strobe", video_rom_strobe, 1'b0);
        for (int p = 9; p <= 11; p++) begin
            cyc();
            chk("wr_we_n_low", sram_we_n, 1'b0);
            chk("wr_oe_n_high", sram_oe_n, 1'b1);
            chk("wr_ack_early", cpu_ack, 1'b0);
        end
        cyc();
        chk("wr_p12_ack", cpu_ack, 1'b1);
        chk("wr_p12_we_n", sram_we_n, 1'b1);
        chk("wr_p12_dout", sram_dout, 8'hA5);
        cpu_req = 1'b0; cpu_we = 1'b0;
        cyc();
        chk("wr_p13_ack", cpu_ack, 1'b0);
        chk("wr_mem", mem[17'h00100], 8'hA5);

        // read back 00100; meanwhile bit 11 of video_addr must be ignored
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00100;
        goto(4'd1);
        chk("bit11_ignored", sram_addr, 17'h0800A);
        goto(4'd8);
        chk("rd_p8_addr", sram_addr, 17'h00100);
        chk("rd_p8_oe_n", sram_oe_n, 1'b1);
        cyc();
        chk("rd_p9_oe_n", sram_oe_n, 1'b0);
        chk("rd_p9_we_n", sram_we_n, 1'b1);
        goto(4'd11);
        chk("rd_p11_oe_n", sram_oe_n, 1'b0);
        cyc();
        chk("rd_p12_ack", cpu_ack, 1'b1);
        chk("rd_p12_rdata", cpu_rdata, 8'hA5);
        chk("rd_p12_oe_n", sram_oe_n, 1'b1);
        cpu_req = 1'b0;

        // idle slot, then request raised in phase 9: latency 19 clk
        goto(4'd9);
        chk("idle_oe_n", sram_oe_n, 1'b1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h08005;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cpu_ack) begin lat = i; break; end
        end
        chk("late_req_latency", lat, 19);
        chk("late_req_rdata", cpu_rdata, 8'h41);
        cpu_req = 1'b0;

        // char_sync in phase 10 of a write aborts it; retried next period
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00200; cpu_wdata = 8'h5A;
        goto(4'd10);
        chk("abort_p10_we_n", sram_we_n, 1'b0);
        char_sync = 1'b1;
        cyc(); char_sync = 1'b0;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_ack", cpu_ack, 1'b0);
        chk("abort_ram_strobe", video_ram_strobe, 1'b1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cpu_ack) begin lat = i; break; end
        end
        chk("retry_latency", lat, 12);
        cpu_req = 1'b0; cpu_we = 1'b0;
        chk("retry_mem", mem[17'h00200], 8'h5A);

        // address wrap with VRAM_BASE = 1FFFF
        goto(4'd15);
        video_addr = 12'h002;
        goto(4'd1);
        chk("wrap_addr", w_sram_addr, 17'h00001);
        chk("base_addr", sram_addr, 17'h08002);

        // asynchronous reset in phase 10 of a read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00100;
        goto(4'd10);
        chk("rr_p10_oe_n", sram_oe_n, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rr_oe_n", sram_oe_n, 1'b1);
        chk("rr_ack", cpu_ack, 1'b0);
        chk("rr_addr", sram_addr, 17'h0);
        chk("rr_ram_strobe", video_ram_strobe, 1'b0);
        cpu_req = 1'b0;
        ph = 4'd0;
        cyc();
        chk("rr_held_ack", cpu_ack, 1'b0);
        reset_n = 1'b1;
        cyc();
        chk("rr_restart_strobe", video_ram_strobe, 1'b1);
        chk("rr_restart_oe_n", sram_oe_n, 1'b0);
        chk("rr_restart_addr", sram_addr, 17'h08002);
        goto(4'd12);
        chk("rr_no_ack", cpu_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
